// File: rtl/din_ser_pkg.sv
// Shared types and limits for the Din serializer feeding the 1101 detector.
package din_ser_pkg;

  // Serializer FSM states; SER_PARITY is only reachable when the
  // DIN_SERIALIZER_PARITY_EN build option is defined.
  typedef enum logic [1:0] {
    SER_IDLE   = 2'b00,
    SER_SHIFT  = 2'b01,
    SER_PARITY = 2'b10
  } ser_state_t;

  // Widest word the serializer is intended to handle.
  localparam int SER_WIDTH_MAX = 32;

endpackage

// File: rtl/din_serializer.sv
// Parallel-to-serial front end for the 1101 sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake and streams one bit per
// Clk on Din, back-to-back with no idle gap between words.
// Build option: define DIN_SERIALIZER_PARITY_EN to append one even-parity bit
// after every word (words then occupy WIDTH+1 cycles).
// WIDTH is meant to stay within 2..SER_WIDTH_MAX.
module din_serializer
  import din_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Wr_Data,
  input  logic             Wr_Valid,
  output logic             Wr_Ready,
  output logic             Din,
  output logic             Din_Valid,
  output logic             Busy,
  output logic             Word_Done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             din_nxt;
  logic             din_valid_nxt;
  logic             word_done_nxt;
  logic             handshake;
`ifdef DIN_SERIALIZER_PARITY_EN
  logic             parity, parity_nxt;
`endif

  // Bit that goes out on Din while the register holds v.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Register contents after the current head bit has been consumed.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign handshake = Wr_Valid && Wr_Ready;

  // Ready depends on state only: idle, or the final cycle of the word
  // (last payload bit without parity, the parity bit with it).
  always_comb begin
    Wr_Ready = 1'b0;
    case (state)
      SER_IDLE:   Wr_Ready = 1'b1;
`ifdef DIN_SERIALIZER_PARITY_EN
      SER_SHIFT:  Wr_Ready = 1'b0;
      SER_PARITY: Wr_Ready = 1'b1;
`else
      SER_SHIFT:  Wr_Ready = (cnt == CNT_LAST);
`endif
      default:    Wr_Ready = 1'b0;
    endcase
  end

  // Next-state, shift register, counter and the registered output values,
  // all derived from where the FSM will be in the coming cycle.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
`ifdef DIN_SERIALIZER_PARITY_EN
    parity_nxt = parity;
`endif

    case (state)
      SER_IDLE: begin
        if (handshake) begin
          state_nxt = SER_SHIFT;
          sr_nxt    = Wr_Data;
          cnt_nxt   = '0;
`ifdef DIN_SERIALIZER_PARITY_EN
          parity_nxt = ^Wr_Data;
`endif
        end
      end

      SER_SHIFT: begin
        if (cnt == CNT_LAST) begin
          if (handshake) begin
            state_nxt = SER_SHIFT;
            sr_nxt    = Wr_Data;
            cnt_nxt   = '0;
`ifdef DIN_SERIALIZER_PARITY_EN
            parity_nxt = ^Wr_Data;
`endif
          end else begin
            sr_nxt  = '0;
            cnt_nxt = '0;
`ifdef DIN_SERIALIZER_PARITY_EN
            state_nxt = SER_PARITY;
`else
            state_nxt = SER_IDLE;
`endif
          end
        end else begin
          sr_nxt  = shift_once(sr);
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

`ifdef DIN_SERIALIZER_PARITY_EN
      SER_PARITY: begin
        if (handshake) begin
          state_nxt  = SER_SHIFT;
          sr_nxt     = Wr_Data;
          cnt_nxt    = '0;
          parity_nxt = ^Wr_Data;
        end else begin
          state_nxt = SER_IDLE;
        end
      end
`endif

      default: begin
        state_nxt = SER_IDLE;
        sr_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase

    din_valid_nxt = (state_nxt != SER_IDLE);
    word_done_nxt = (state_nxt == SER_SHIFT) && (cnt_nxt == CNT_LAST);
    din_nxt       = 1'b0;
    if (state_nxt == SER_SHIFT) begin
      din_nxt = head_bit(sr_nxt);
    end
`ifdef DIN_SERIALIZER_PARITY_EN
    if (state_nxt == SER_PARITY) begin
      din_nxt = parity_nxt;
    end
`endif
  end

  // State and output registers; reset drops any in-flight word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= SER_IDLE;
      sr        <= '0;
      cnt       <= '0;
      Din       <= 1'b0;
      Din_Valid <= 1'b0;
      Busy      <= 1'b0;
      Word_Done <= 1'b0;
`ifdef DIN_SERIALIZER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      Din       <= din_nxt;
      Din_Valid <= din_valid_nxt;
      Busy      <= din_valid_nxt;
      Word_Done <= word_done_nxt;
`ifdef DIN_SERIALIZER_PARITY_EN
      parity    <= parity_nxt;
`endif
    end
  end

endmodule

// File: doc/din_serializer.md
Name: din_serializer

Overview:
- Parallel-to-serial front end for the 1101 sequence-detector path.
- Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per Clk on Din, which drives the detector's serial Din input directly.
- Sustains back-to-back words with no idle gap, so an unbroken bitstream can be streamed.
- Din_Valid qualifies each emitted bit for monitors and scoreboards.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- Clk  input  1  clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Wr_Data  input  WIDTH  parallel word; sampled only on handshake.
- Wr_Valid  input  1  producer has a word.
- Wr_Ready  output  1  block can accept a word this cycle; combinational from state only.
- Din  output  1  serial bit to the detector; registered.
- Din_Valid  output  1  Din carries a payload (or parity) bit this cycle; registered.
- Busy  output  1  high whenever state != IDLE; registered.
- Word_Done  output  1  one-cycle pulse coincident with the last bit of a word; registered.

Behaviour:
- Reset values: Din=0, Din_Valid=0, Busy=0, Word_Done=0, state=IDLE, shift register=0, bit counter=0. Wr_Ready=1 one cycle after Rst deasserts.
- Handshake: transfer occurs on a rising edge with Wr_Valid && Wr_Ready. Wr_Valid may be held with no transfer; Wr_Data is ignored when there is no transfer.
- Wr_Ready:
  - 1 in IDLE.
  - 1 in SHIFT during the last bit cycle (counter==WIDTH-1) when parity is compiled out.
  - 0 otherwise.
- Latency: word accepted at edge N; its first bit appears on Din/Din_Valid for the cycle following edge N. WIDTH consecutive bit cycles follow, with no bubbles.
- State machine:
  - IDLE: Din=0, Din_Valid=0. On handshake, load shift register and counter=0, go to SHIFT.
  - SHIFT: present the current bit and increment the counter.
  - At counter==WIDTH-1: assert Word_Done.
    - Handshake in the same cycle: reload and stay in SHIFT (back-to-back, zero gap).
    - Otherwise, with parity compiled out: go to IDLE.
    - Otherwise, with parity compiled in: go to PARITY.
  - PARITY (macro only): one cycle emitting the parity bit with Din_Valid=1. Wr_Ready=1 in this cycle; handshake → SHIFT, else → IDLE.
- Idle fill: Din is driven 0 whenever Din_Valid=0. The detector therefore sees 0s between words, which clears any partial match; this is intended.
- Bit ordering:
  - MSB_FIRST=1: shift left and emit sr[WIDTH-1].
  - MSB_FIRST=0: shift right and emit sr[0].
- Word_Done: pulses exactly once per word, on the last payload bit, never on the parity bit.
- Reset mid-word: the in-flight word is dropped and all outputs return to reset values at that edge. A handshake in the same cycle as Rst is ignored.
- Counter width: $clog2(WIDTH). The counter never wraps past WIDTH-1.

Optional Feature:
- Macro: DIN_SERIALIZER_PARITY_EN.
- Defined: each word is followed by one even-parity bit (XOR of the WIDTH payload bits), with Din_Valid=1. Words occupy WIDTH+1 cycles, and Wr_Ready is asserted only in the PARITY cycle, not in the last payload cycle.
- Undefined: no PARITY state exists; words occupy WIDTH cycles.

Decomposition:
- Shared package din_ser_pkg holds:
  - typedef enum logic [1:0] ser_state_t {SER_IDLE=2'b00, SER_SHIFT=2'b01, SER_PARITY=2'b10}.
  - localparam SER_WIDTH_MAX=32.
- No sub-module: shift register, counter and FSM together fit in a single module of roughly 150 lines.

Test Plan:
- Ordering and latency: WIDTH=4, MSB_FIRST=1; a single word 4'b1101 with Wr_Valid held for 1 cycle → Din=1,1,0,1 over 4 consecutive cycles starting the cycle after acceptance; Din_Valid high for exactly those 4 cycles; Word_Done only on the 4th cycle; Busy falls after it.
- Back-to-back: words 4'hD then 4'hB with Wr_Valid held continuously → 8 contiguous valid bits 1101 1011; Wr_Ready=1 only in IDLE and in bit-cycle 4; Word_Done pulses on cycles 4 and 8. Feeding the detector yields Y=1 on cycle 4 and again on cycle 7, since the overlap 1101 is formed by the last bit of word 1 plus 101 of word 2.
- LSB-first and backpressure: MSB_FIRST=0, word 4'b1011, Wr_Valid asserted while Busy → Din=1,1,0,1; the second word is accepted only in the last bit cycle, and Wr_Data changes while Wr_Ready=0 have no effect.
- Reset mid-word: Rst asserted during bit 2 of 8'hA5 → Din, Din_Valid, Busy and Word_Done are all 0 at the next edge and no Word_Done pulse occurs; a fresh 8'h3C afterwards serialises correctly.
- Parity (DIN_SERIALIZER_PARITY_EN defined): 4'b1101 → Din=1,1,0,1,1 (parity=1) with Din_Valid high for 5 cycles; Word_Done on cycle 4; Wr_Ready=1 only on cycle 5.
